seq_shift_add_mul: RTL
======================

// Module: seq_shift_add_mul
// PURPOSE
//  Multi-cycle unsigned 8x8 multiplier built around the 8-bit ripple-carry adder (ripplemod).
//  Sits directly upstream of ripplemod: each RUN cycle it drives the adder operands,
//  then consumes the returned sum/cout.
//  Provides the ALU MUL operation behind valid/ready handshakes; one op in flight at a time.
// PARAMETERS
//  WIDTH   8   operand width; only 8 is legal (matches ripplemod); any other value -> elaboration error
// PORTS
//  clk        in   1    single clock, all state updates on rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    operand request valid
//  in_ready   out  1    block can accept operands (high only in IDLE)
//  a          in   8    multiplicand, sampled on accept
//  b          in   8    multiplier, sampled on accept
//  out_valid  out  1    product valid (high only in DONE)
//  out_ready  in   1    consumer takes product
//  product    out  16   a*b, unsigned
//  zero       out  1    product == 16'h0000
//  ovf8       out  1    product[15:8] != 0 (result does not fit in 8 bits)
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, P=0, mcand=0, cnt=0.
//    Outputs while in reset: product=0, zero=0, ovf8=0, out_valid=0, busy=0, in_ready=1.
//  - Registers: P[15:0] (P[15:8] = partial sum, P[7:0] = multiplier), mcand[7:0], cnt[2:0].
//  - Accept: edge where in_valid & in_ready. On that edge: P<={8'h00,b}, mcand<=a, cnt<=0, state<=RUN.
//  - RUN, one step per edge; ripplemod instance: a=P[15:8], b=(P[0] ? mcand : 8'h00), cin=0.
//    Each step: P <= {cout, sum, P[7:1]}; cnt <= cnt+1.
//    On the step with cnt==7: state <= DONE.
//  - Latency: accept on edge k -> out_valid=1 after edge k+8. Product is valid from that same edge.
//  - DONE: out_valid=1. product/zero/ovf8 are driven from P, and zero/ovf8 are registered together with the final P.
//    These values stay stable until the out handshake.
//    Edge with out_ready=1 -> IDLE; out_valid drops after that edge.
//  - Throughput with out_ready tied 1: one accept every 10 edges.
//  - in_valid during RUN/DONE: ignored (in_ready=0). a/b changes after accept: no effect.
//  - out_ready during IDLE/RUN: ignored.
//  - Accept and out handshake are never simultaneous: in_ready and out_valid are mutually exclusive.
//  - Reset mid-operation: immediate return to reset values; the partial product is discarded, no out_valid pulse.
//  - Arithmetic: unsigned only. A 9-bit {cout,sum} per step cannot overflow the P shift; the final P is the exact 16-bit product.
//  - Outside DONE: product holds the last P value. zero/ovf8 keep their last DONE values (0 after reset).
// CONFIGURATION
//  SEQ_MUL_ZERO_SKIP_EN defined:
//    On accept with a==0 or b==0: P<=0, zero<=1, ovf8<=0, state<=DONE directly.
//    out_valid after edge k (latency 0 edges past accept; throughput 2 edges/op).
//  SEQ_MUL_ZERO_SKIP_EN undefined:
//    Zero operands take the full 8-step RUN path; latency always 8.
// TESTING
//  1. a=8'h0F, b=8'h0B, out_ready=1
//     -> out_valid exactly 8 edges after accept; product=16'h00A5, zero=0, ovf8=0.
//  2. a=8'hFF, b=8'hFF (exercises cout every step)
//     -> product=16'hFE01, ovf8=1, zero=0.
//  3. Hold out_ready=0 for 5 cycles in DONE, toggle in_valid/a/b meanwhile
//     -> product stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
//  4. a=8'h03, b=8'h05; assert rst_n=0 after 4th RUN step
//     -> out_valid=0, busy=0, in_ready=1 immediately.
//     Release reset, accept a=8'h07, b=8'h09 -> product=16'h003F after 8 edges.
//  5. a=8'h00, b=8'h37
//     -> product=0, zero=1; out_valid after 8 edges without SEQ_MUL_ZERO_SKIP_EN, on the accept edge with it.
//  6. Back-to-back: in_valid=1, out_ready=1 for 3 ops (2*3, 8'h80*2, 8'h10*8'h10)
//     -> accepts spaced 10 edges; products 16'h0006, 16'h0100, 16'h0100; ovf8=0,1,1.

Source files
------------

// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: 8x8 unsigned shift-add multiplier over ripplemod; SEQ_MUL_ZERO_SKIP_EN short-cuts zero operands
module ripplemod (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] w_c;
  assign w_c[0] = cin;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  assign cout = w_c[8];
endmodule

module seq_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               zero,
  output logic               ovf8,
  output logic               busy
);
  if (WIDTH != 8) begin : g_bad_width
    $error("seq_shift_add_mul: WIDTH must be 8");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      r_state, w_state_n;
  logic [15:0] r_p, w_p_next;
  logic [7:0]  r_mcand, w_sum;
  logic [2:0]  r_cnt;
  logic        r_zero, r_ovf8, w_cout, w_accept, w_skip;
  ripplemod u_add (
    .a    (r_p[15:8]),
    .b    (r_p[0] ? r_mcand : 8'h00),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );
  assign w_p_next = {w_cout, w_sum, r_p[7:1]};
  assign w_accept = in_valid & in_ready;
`ifdef SEQ_MUL_ZERO_SKIP_EN
  assign w_skip = (a == 8'h00) || (b == 8'h00);
`else
  assign w_skip = 1'b0;
`endif
  always_comb begin
    w_state_n = r_state;
    if (r_state == IDLE && in_valid) w_state_n = w_skip ? DONE : RUN;
    else if (r_state == RUN && r_cnt == 3'd7) w_state_n = DONE;
    else if (r_state == DONE && out_ready) w_state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_n;
  end
  // zero/ovf8 are captured from the final step so they stay valid through DONE and after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p     <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_ovf8  <= 1'b0;
    end else if (w_accept) begin
      r_p     <= w_skip ? 16'h0000 : {8'h00, b};
      r_mcand <= a;
      r_cnt   <= '0;
      if (w_skip) begin
        r_zero <= 1'b1;
        r_ovf8 <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_p   <= w_p_next;
      r_cnt <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) begin
        r_zero <= (w_p_next == 16'h0000);
        r_ovf8 <= |w_p_next[15:8];
      end
    end
  end
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign product   = r_p;
  assign zero      = r_zero;
  assign ovf8      = r_ovf8;
endmodule
